ex_muldiv: RTL and testbench

Multi-cycle RV32M execute unit that sits beside the single-cycle `ex` ALU in the EX stage. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Multiplies use a parametrised-depth pipelined multiplier; divides use an iterative restoring divider. Operands are XLEN bits wide, and the block completes one operation at a time under a valid/ready handshake with flush support.

---
 rtl/ex_muldiv_if.sv | 39 +++
 rtl/ex_muldiv.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if
// Operation/result bundle between the EX stage and the multi-cycle RV32M unit.
//   master : issuing side (drives the operation, observes completion)
//   slave  : ex_muldiv (accepts the operation, drives the completion)
// Signals:
//   flush_i   kill any in-flight operation
//   valid_i   new operation present
//   ready_o   unit can accept (IDLE only)
//   funct3_i  RISC-V M funct3
//   rs1_i/rs2_i operands, rd_i destination register
//   valid_o   one-cycle completion pulse, rd_o/result_o completed op
//   busy_o    inverse of ready_o
// ---------------------------------------------------------------------------
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            valid_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output flush_i, valid_i, funct3_i, rs1_i, rs2_i, rd_i,
        input  ready_o, valid_o, rd_o, result_o, busy_o
    );

    modport slave (
        input  flush_i, valid_i, funct3_i, rs1_i, rs2_i, rd_i,
        output ready_o, valid_o, rd_o, result_o, busy_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// Multi-cycle RV32M execute unit: MUL/MULH/MULHSU/MULHU through a
// MUL_STAGES-deep pipelined multiplier, DIV/DIVU/REM/REMU through an
// iterative restoring divider. One operation in flight at a time.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (dominates rdy and flush)
//   rdy   global enable; all state holds while low
//   bus   ex_muldiv_if slave modport (operation in, completion out)
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    ex_muldiv_if.slave      bus
);

    localparam int CW = $clog2(XLEN + MUL_STAGES + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic [2*XLEN-1:0]   r_ma;
    logic [2*XLEN-1:0]   r_mb;
    logic [2*XLEN-1:0]   r_pipe [MUL_STAGES];
    logic [XLEN-1:0]     r_dvd;      // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]     r_dvs;
    logic [XLEN:0]       r_rem;      // partial remainder
    logic                r_q_neg;
    logic                r_r_neg;
    logic [XLEN-1:0]     r_pend;     // divide result (special case or fixed up)
    logic                r_valid;
    logic [4:0]          r_rd_out;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_sgn_div;
    logic                w_rem_op;
    logic                w_neg_a;
    logic                w_neg_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic                w_ma_sgn;
    logic                w_mb_sgn;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN+1:0]     w_diff;
    logic [XLEN-1:0]     w_fix_res;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_mul_res;
    logic                w_ready;

    assign w_accept   = rdy & ~bus.flush_i & bus.valid_i & (r_state == S_IDLE);
    assign w_sgn_div  = ~bus.funct3_i[0];
    assign w_rem_op   = bus.funct3_i[1];
    assign w_neg_a    = w_sgn_div & bus.rs1_i[XLEN-1];
    assign w_neg_b    = w_sgn_div & bus.rs2_i[XLEN-1];
    assign w_div_zero = (bus.rs2_i == {XLEN{1'b0}});
    assign w_ovf      = w_sgn_div & (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                                  & (bus.rs2_i == {XLEN{1'b1}});
    assign w_special  = bus.funct3_i[2] & (w_div_zero | w_ovf);
    assign w_ma_sgn   = (bus.funct3_i == 3'd1) | (bus.funct3_i == 3'd2);
    assign w_mb_sgn   = (bus.funct3_i == 3'd1);

    // Trial subtract of one restoring step; a set top bit means it went negative.
    assign w_diff = {r_rem, r_dvd[XLEN-1]} - {2'b00, r_dvs};

    // Operands are sign/zero extended to 2*XLEN, so the low 2*XLEN bits of
    // a plain product are the correct signed/unsigned/mixed product.
    assign w_prod    = r_ma * r_mb;
    assign w_mul_res = (r_op == 3'd0) ? r_pipe[MUL_STAGES-1][XLEN-1:0]
                                      : r_pipe[MUL_STAGES-1][2*XLEN-1:XLEN];

    // Divide special-case result chosen at acceptance
    always_comb begin
        w_special_res = {XLEN{1'b0}};
        if (w_div_zero) begin
            w_special_res = w_rem_op ? bus.rs1_i : {XLEN{1'b1}};
        end else if (w_ovf) begin
            w_special_res = w_rem_op ? {XLEN{1'b0}} : bus.rs1_i;
        end else begin
            w_special_res = {XLEN{1'b0}};
        end
    end

    // Sign fix-up of the unsigned quotient/remainder
    always_comb begin
        w_fix_res = {XLEN{1'b0}};
        if (r_op[1]) begin
            w_fix_res = r_r_neg ? ({XLEN{1'b0}} - r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];
        end else begin
            w_fix_res = r_q_neg ? ({XLEN{1'b0}} - r_dvd) : r_dvd;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_next;
        end else begin
            r_state <= r_state;
        end
    end

    // FSM next-state logic; flush overrides both acceptance and completion
    always_comb begin
        w_next = r_state;
        if (bus.flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.valid_i)          w_next = S_IDLE;
                    else if (!bus.funct3_i[2]) w_next = S_MUL;
                    else if (w_special)        w_next = S_DONE;
                    else                       w_next = S_DIV;
                end
                S_MUL:   w_next = (r_cnt == MUL_LAST) ? S_DONE : S_MUL;
                S_DIV:   w_next = (r_cnt == DIV_LAST) ? S_FIX : S_DIV;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs: ready purely from state
    always_comb begin
        w_ready = 1'b0;
        if (r_state == S_IDLE) begin
            w_ready = 1'b1;
        end else begin
            w_ready = 1'b0;
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.busy_o   = ~w_ready;
    assign bus.valid_o  = r_valid;
    assign bus.rd_o     = r_rd_out;
    assign bus.result_o = r_result;

    // Operand capture, iteration counter and divider datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= {CW{1'b0}};
            r_op    <= 3'd0;
            r_rd    <= 5'd0;
            r_ma    <= {(2*XLEN){1'b0}};
            r_mb    <= {(2*XLEN){1'b0}};
            r_dvd   <= {XLEN{1'b0}};
            r_dvs   <= {XLEN{1'b0}};
            r_rem   <= {(XLEN+1){1'b0}};
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_pend  <= {XLEN{1'b0}};
        end else if (rdy) begin
            if (w_accept) begin
                r_cnt   <= {CW{1'b0}};
                r_op    <= bus.funct3_i;
                r_rd    <= bus.rd_i;
                r_ma    <= {{XLEN{w_ma_sgn & bus.rs1_i[XLEN-1]}}, bus.rs1_i};
                r_mb    <= {{XLEN{w_mb_sgn & bus.rs2_i[XLEN-1]}}, bus.rs2_i};
                r_dvd   <= w_neg_a ? ({XLEN{1'b0}} - bus.rs1_i) : bus.rs1_i;
                r_dvs   <= w_neg_b ? ({XLEN{1'b0}} - bus.rs2_i) : bus.rs2_i;
                r_rem   <= {(XLEN+1){1'b0}};
                r_q_neg <= w_neg_a ^ w_neg_b;
                r_r_neg <= w_neg_a;
                r_pend  <= w_special_res;
            end else begin
                case (r_state)
                    S_MUL: begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    S_DIV: begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_diff[XLEN+1]) begin
                            r_rem <= {r_rem[XLEN-1:0], r_dvd[XLEN-1]};
                            r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
                        end else begin
                            r_rem <= w_diff[XLEN:0];
                            r_dvd <= {r_dvd[XLEN-2:0], 1'b1};
                        end
                    end
                    S_FIX: begin
                        r_pend <= w_fix_res;
                    end
                    default: begin
                        r_cnt <= r_cnt;
                    end
                endcase
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Multiplier pipeline: stage 0 multiplies, later stages only delay
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_pipe[i] <= {(2*XLEN){1'b0}};
            end
        end else if (rdy) begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end else begin
            r_pipe[0] <= r_pipe[0];
        end
    end

    // Registered completion; flush suppresses the pulse but keeps result/rd
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_rd_out <= 5'd0;
            r_result <= {XLEN{1'b0}};
        end else if (rdy) begin
            if (bus.flush_i) begin
                r_valid <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_valid  <= 1'b1;
                r_rd_out <= r_rd;
                r_result <= r_op[2] ? r_pend : w_mul_res;
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= r_valid;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv
// Directed checks of the RV32M unit (latency, special cases, flush, stall,
// reset) followed by a back-to-back random stream compared with a plain
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam int MS   = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(XLEN)) bus ();

    ex_muldiv #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics with 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after accept edge E.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        chk("ready_before_accept", 32'(bus.ready_o), 32'd1);
        bus.funct3_i = f;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.rd_i     = rd;
        bus.valid_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i  = 1'b0;
    endtask

    // Counts edges after E until valid_o is seen; optionally drops rdy for a window.
    task automatic wait_valid(input int stall_at, input int stall_len, output int lat);
        int k;
        k   = 0;
        lat = -1;
        while (k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                lat = k;
                break;
            end
            if (k == stall_at) rdy = 1'b0;
            if (k == stall_at + stall_len) rdy = 1'b1;
        end
        rdy = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int stall_at, input int stall_len);
        int lat;
        start_op(f, a, b, rd);
        wait_valid(stall_at, stall_len, lat);
        chk({tag, "_res"}, bus.result_o, exp_res);
        chk({tag, "_rd"}, 32'(bus.rd_o), 32'(rd));
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        int          n;
        logic [36:0] expq [$];
        logic [36:0] e;
        logic [2:0]  cf;
        logic [31:0] ca, cb;
        logic [4:0]  crd;
        int          sent, got, dup, acc_last;

        rst = 1'b1;
        rdy = 1'b1;
        bus.flush_i  = 1'b0;
        bus.valid_i  = 1'b0;
        bus.funct3_i = 3'd0;
        bus.rs1_i    = 32'h0;
        bus.rs2_i    = 32'h0;
        bus.rd_i     = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_rd", 32'(bus.rd_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;

        // Multiplies
        run_op("mul",    3'd0, 32'hFFFFFFFF, 32'd2, 5'd1, 32'hFFFFFFFE, MS + 1, 0, 0);
        run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'd2, 5'd2, 32'hFFFFFFFF, MS + 1, 0, 0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'd2, 5'd3, 32'h00000001, MS + 1, 0, 0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, MS + 1, 0, 0);

        // Normal divides
        run_op("div",  3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, XLEN + 2, 0, 0);
        run_op("rem",  3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, XLEN + 2, 0, 0);
        run_op("divu", 3'd5, 32'hFFFFFFF9, 32'd2, 5'd7, 32'h7FFFFFFC, XLEN + 2, 0, 0);

        // Special cases
        run_op("div0",    3'd4, 32'd1234, 32'd0, 5'd8, 32'hFFFFFFFF, 1, 0, 0);
        run_op("remu0",   3'd7, 32'd5, 32'd0, 5'd9, 32'd5, 1, 0, 0);
        run_op("divovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1, 0, 0);
        run_op("removf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h0, 1, 0, 0);
        @(negedge clk);
        chk("valid_one_cycle", 32'(bus.valid_o), 32'd0);

        // Flush mid-divide at E+10
        prev_res = bus.result_o;
        prev_rd  = bus.rd_o;
        start_op(3'd4, 32'd100, 32'd7, 5'd12);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_ready", 32'(bus.ready_o), 32'd1);
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        chk("flush_result_kept", bus.result_o, prev_res);
        chk("flush_rd_kept", 32'(bus.rd_o), 32'(prev_rd));
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) n++;
        end
        chk("flush_no_valid", 32'(n), 32'd0);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd13, 32'd12, MS + 1, 0, 0);

        // Stall during divide: 5 rdy-low cycles
        run_op("div_stall", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd14, 32'hFFFFFFFD, XLEN + 2 + 5, 3, 5);

        // Reset in the middle of a multiply
        start_op(3'd0, 32'd5, 32'd6, 5'd15);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(bus.valid_o), 32'd0);
        chk("midrst_rd", 32'(bus.rd_o), 32'd0);
        chk("midrst_result", bus.result_o, 32'd0);
        chk("midrst_ready", 32'(bus.ready_o), 32'd1);
        chk("midrst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) n++;
        end
        chk("midrst_no_valid", 32'(n), 32'd0);

        // Back-to-back random stream with valid_i held high
        sent = 0; got = 0; dup = 0; acc_last = 0;
        cf = 3'($urandom_range(0, 7)); ca = pick(); cb = pick(); crd = 5'($urandom_range(1, 31));
        bus.funct3_i = cf; bus.rs1_i = ca; bus.rs2_i = cb; bus.rd_i = crd;
        bus.valid_i  = 1'b1;
        for (int cyc = 0; cyc < 3000 && got < 20; cyc++) begin
            if (bus.valid_o === 1'b1) begin
                if (expq.size() == 0) begin
                    dup++;
                end else begin
                    e = expq.pop_front();
                    got++;
                    chk("b2b_res", bus.result_o, e[31:0]);
                    chk("b2b_rd", 32'(bus.rd_o), 32'(e[36:32]));
                end
            end
            if (acc_last != 0) begin
                acc_last = 0;
                if (sent < 20) begin
                    cf = 3'($urandom_range(0, 7)); ca = pick(); cb = pick();
                    crd = 5'($urandom_range(1, 31));
                    bus.funct3_i = cf; bus.rs1_i = ca; bus.rs2_i = cb; bus.rd_i = crd;
                end else begin
                    bus.valid_i = 1'b0;
                end
            end
            if (bus.valid_i && bus.ready_o === 1'b1) begin
                expq.push_back({crd, ref_op(cf, ca, cb)});
                sent++;
                acc_last = 1;
            end
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        chk("b2b_completions", 32'(got), 32'd20);
        chk("b2b_duplicates", 32'(dup), 32'd0);
        chk("b2b_pending", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
